// File: rtl/cmp_pkg.sv
// cmp_pkg: shared comparator-datapath constants, FSM state encoding and saturating counter helper
//  CW       data width of the comparator cell
//  SWAP_MAX ceiling of the swap counter
//  state_t  sort-engine FSM states
package cmp_pkg;
   localparam int CW       = 4;
   localparam int SWAP_MAX = 255;
   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      LOAD   = 2'd1,
      SORT   = 2'd2,
      UNLOAD = 2'd3
   } state_t;
   function automatic logic [7:0] sat_inc(input logic [7:0] v);
      return (v == 8'(SWAP_MAX)) ? v : v + 8'd1;
   endfunction
endpackage

// File: rtl/cmp_sort_engine_cmp.sv
// cmp_sort_engine_cmp: 4-bit magnitude comparator cell
//  a3..a0    in   word A, a3 is the MSB
//  b3..b0    in   word B, b3 is the MSB
//  a_bigger  out  A > B
//  b_bigger  out  B > A
//  equal     out  A == B
module cmp_sort_engine_cmp (
   input  logic a3,
   input  logic a2,
   input  logic a1,
   input  logic a0,
   input  logic b3,
   input  logic b2,
   input  logic b1,
   input  logic b0,
   output logic a_bigger,
   output logic b_bigger,
   output logic equal
);
   logic [3:0] w_a;
   logic [3:0] w_b;
   assign w_a      = {a3, a2, a1, a0};
   assign w_b      = {b3, b2, b1, b0};
   assign a_bigger = w_a > w_b;
   assign b_bigger = w_b > w_a;
   assign equal    = w_a == w_b;
endmodule

// File: rtl/cmp_sort_engine.sv
// cmp_sort_engine: buffers up to DEPTH 4-bit words and bubble-sorts them with one comparator cell
//  clk        in   clock, rising edge
//  rst        in   asynchronous active-high reset
//  in_valid   in   in_data valid
//  in_ready   out  a word is accepted this cycle
//  in_data    in   word to load
//  start      in   pulse: sort the loaded words
//  busy       out  sorting or unloading
//  out_valid  out  out_data valid
//  out_ready  in   downstream accepts out_data
//  out_data   out  sorted word
//  out_last   out  final word of the batch
//  swaps      out  swaps made by the last sort, saturating
module cmp_sort_engine
   import cmp_pkg::*;
#(
   parameter int DEPTH  = 8,
   parameter bit ASCEND = 1'b1
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [CW-1:0] in_data,
   input  logic          start,
   output logic          busy,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [CW-1:0] out_data,
   output logic          out_last,
   output logic [7:0]    swaps
);
   localparam int IW = $clog2(DEPTH);
   localparam int NW = $clog2(DEPTH + 1);
   state_t          r_state;
   state_t          w_next;
   logic [CW-1:0]   r_buf [DEPTH];
   logic [NW-1:0]   r_count;
   logic [NW-1:0]   r_pass;
   logic [IW-1:0]   r_i;
   logic [IW-1:0]   r_j;
   logic            r_pass_swap;
   logic [7:0]      r_swaps;
   logic [IW-1:0]   w_i1;
   logic [CW-1:0]   w_a;
   logic [CW-1:0]   w_b;
   logic            w_a_bigger;
   logic            w_b_bigger;
   logic            w_equal;
   logic            w_in_xfer;
   logic            w_out_xfer;
   logic            w_multi;
   logic [NW-1:0]   w_cnt_m1;
   logic            w_swap;
   logic            w_pass_end;
   logic            w_pass_any;
   logic            w_sort_done;
   logic            w_start_go;
   logic            w_last;
   assign w_i1       = r_i + IW'(1);
   assign w_a        = r_buf[r_i];
   assign w_b        = r_buf[w_i1];
   assign w_in_xfer  = in_valid & in_ready;
   assign w_out_xfer = out_valid & out_ready;
   assign w_cnt_m1   = r_count - NW'(1);
   assign w_multi    = r_count > NW'(1);
   // equal words never swap, which keeps the sort stable
   assign w_swap     = (r_state == SORT) & w_multi & ~w_equal & (ASCEND ? w_a_bigger : w_b_bigger);
   // a single-word batch has no pair to compare, so its only SORT cycle ends the pass
   assign w_pass_end = ~w_multi | (NW'(w_i1) == w_cnt_m1);
   assign w_pass_any = r_pass_swap | w_swap;
   assign w_sort_done = w_pass_end & (~w_pass_any | ((r_pass + NW'(1)) == w_cnt_m1));
   // a word arriving together with start belongs to this batch
   assign w_start_go = start & ((r_count != '0) | w_in_xfer);
   assign w_last     = NW'(r_j) == w_cnt_m1;
   assign in_ready   = ((r_state == IDLE) | (r_state == LOAD)) & (r_count < NW'(DEPTH));
   assign busy       = (r_state == SORT) | (r_state == UNLOAD);
   assign out_valid  = r_state == UNLOAD;
   assign out_last   = out_valid & w_last;
   assign out_data   = out_valid ? r_buf[r_j] : '0;
   assign swaps      = r_swaps;
   cmp_sort_engine_cmp u_cmp (
      .a3       (w_a[3]),
      .a2       (w_a[2]),
      .a1       (w_a[1]),
      .a0       (w_a[0]),
      .b3       (w_b[3]),
      .b2       (w_b[2]),
      .b1       (w_b[1]),
      .b0       (w_b[0]),
      .a_bigger (w_a_bigger),
      .b_bigger (w_b_bigger),
      .equal    (w_equal)
   );
   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= IDLE;
      else     r_state <= w_next;
   end
   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE, LOAD: w_next = w_start_go ? SORT : (w_in_xfer ? LOAD : r_state);
         SORT:       w_next = w_sort_done ? UNLOAD : SORT;
         UNLOAD:     w_next = (w_out_xfer & w_last) ? IDLE : UNLOAD;
         default:    w_next = IDLE;
      endcase
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_count     <= '0;
         r_pass      <= '0;
         r_i         <= '0;
         r_j         <= '0;
         r_pass_swap <= 1'b0;
         r_swaps     <= '0;
      end else begin
         if (w_in_xfer) r_count <= r_count + NW'(1);
         if (r_state != SORT && w_next == SORT) begin
            r_i         <= '0;
            r_pass      <= '0;
            r_pass_swap <= 1'b0;
            r_swaps     <= '0;
         end else if (r_state == SORT) begin
            if (w_swap) r_swaps <= sat_inc(r_swaps);
            r_i         <= w_pass_end ? '0 : w_i1;
            r_pass      <= w_pass_end ? r_pass + NW'(1) : r_pass;
            r_pass_swap <= w_pass_end ? 1'b0 : w_pass_any;
            if (w_sort_done) r_j <= '0;
         end
         if (r_state == UNLOAD && w_out_xfer) begin
            r_j <= w_last ? '0 : r_j + IW'(1);
            if (w_last) r_count <= '0;
         end
      end
   end
   // buffer contents are don't-care after reset, so it carries no reset
   always_ff @(posedge clk) begin
      if (w_in_xfer) r_buf[r_count[IW-1:0]] <= in_data;
      if (w_swap) begin
         r_buf[r_i]  <= w_b;
         r_buf[w_i1] <= w_a;
      end
   end
endmodule

// File: tb/tb_cmp_sort_engine.sv
// tb_cmp_sort_engine: directed vector bench for an ascending and a descending sort engine sharing inputs
module tb_cmp_sort_engine;
   logic       clk = 1'b0;
   logic       rst, in_valid, start, out_ready;
   logic [3:0] in_data;
   logic       a_in_ready, a_busy, a_out_valid, a_out_last;
   logic [3:0] a_out_data;
   logic [7:0] a_swaps;
   logic       d_in_ready, d_busy, d_out_valid, d_out_last;
   logic [3:0] d_out_data;
   logic [7:0] d_swaps;
   int checks = 0;
   int failures = 0;
   always #5 clk = ~clk;
   cmp_sort_engine #(.DEPTH(8), .ASCEND(1'b1)) u_asc (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(a_in_ready), .in_data(in_data),
      .start(start), .busy(a_busy), .out_valid(a_out_valid), .out_ready(out_ready),
      .out_data(a_out_data), .out_last(a_out_last), .swaps(a_swaps)
   );
   cmp_sort_engine #(.DEPTH(8), .ASCEND(1'b0)) u_dsc (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(d_in_ready), .in_data(in_data),
      .start(start), .busy(d_busy), .out_valid(d_out_valid), .out_ready(out_ready),
      .out_data(d_out_data), .out_last(d_out_last), .swaps(d_swaps)
   );
   typedef struct {
      int         n;
      logic [3:0] din [8];
      logic [3:0] ea  [8];
      logic [3:0] ed  [8];
      int         sa;
      int         sd;
      bit         sl;
      bit         extra;
      int         stall;
   } vec_t;
   vec_t vecs [5];
   task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask
   task automatic run_batch(input int id);
      int ka = 0;
      int kd = 0;
      int hold = 0;
      int cyc = 0;
      bit stalled = 1'b0;
      for (int k = 0; k < vecs[id].n; k++) begin
         in_valid = 1'b1;
         in_data  = vecs[id].din[k];
         start    = vecs[id].sl && (k == vecs[id].n - 1);
         @(negedge clk);
      end
      in_valid = 1'b0;
      start    = 1'b0;
      if (vecs[id].extra) begin
         chk("full_in_ready_a", {7'd0, a_in_ready}, 8'd0);
         chk("full_in_ready_d", {7'd0, d_in_ready}, 8'd0);
         in_valid = 1'b1;
         in_data  = 4'hf;
         @(negedge clk);
         in_valid = 1'b0;
      end
      if (!vecs[id].sl) begin
         start = 1'b1;
         @(negedge clk);
         start = 1'b0;
      end
      out_ready = 1'b1;
      while ((ka < vecs[id].n || kd < vecs[id].n) && cyc < 400) begin
         @(negedge clk);
         cyc++;
         if (hold > 0) begin
            hold--;
            if (hold == 0) out_ready = 1'b1;
         end
         if (vecs[id].stall >= 0 && !stalled && ka == vecs[id].stall && a_out_valid) begin
            stalled   = 1'b1;
            hold      = 5;
            out_ready = 1'b0;
         end
         if (a_out_valid) begin
            if (ka >= vecs[id].n) chk("extra_word_a", {7'd0, a_out_valid}, 8'd0);
            else begin
               chk($sformatf("v%0d_data_a[%0d]", id, ka), {4'd0, a_out_data}, {4'd0, vecs[id].ea[ka]});
               chk($sformatf("v%0d_last_a[%0d]", id, ka), {7'd0, a_out_last}, {7'd0, ka == vecs[id].n - 1});
               if (out_ready) ka++;
            end
         end
         if (d_out_valid) begin
            if (kd >= vecs[id].n) chk("extra_word_d", {7'd0, d_out_valid}, 8'd0);
            else begin
               chk($sformatf("v%0d_data_d[%0d]", id, kd), {4'd0, d_out_data}, {4'd0, vecs[id].ed[kd]});
               chk($sformatf("v%0d_last_d[%0d]", id, kd), {7'd0, d_out_last}, {7'd0, kd == vecs[id].n - 1});
               if (out_ready) kd++;
            end
         end
      end
      chk($sformatf("v%0d_words_a", id), 8'(ka), 8'(vecs[id].n));
      chk($sformatf("v%0d_words_d", id), 8'(kd), 8'(vecs[id].n));
      @(negedge clk);
      out_ready = 1'b0;
      chk($sformatf("v%0d_idle_valid_a", id), {7'd0, a_out_valid}, 8'd0);
      chk($sformatf("v%0d_idle_valid_d", id), {7'd0, d_out_valid}, 8'd0);
      chk($sformatf("v%0d_idle_busy_a", id), {7'd0, a_busy}, 8'd0);
      chk($sformatf("v%0d_idle_ready_a", id), {7'd0, a_in_ready}, 8'd1);
      chk($sformatf("v%0d_swaps_a", id), a_swaps, 8'(vecs[id].sa));
      chk($sformatf("v%0d_swaps_d", id), d_swaps, 8'(vecs[id].sd));
   endtask
   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end
   initial begin
      vecs[0] = '{n: 3, din: '{3, 1, 2, 0, 0, 0, 0, 0}, ea: '{1, 2, 3, 0, 0, 0, 0, 0},
                  ed: '{3, 2, 1, 0, 0, 0, 0, 0}, sa: 2, sd: 1, sl: 0, extra: 0, stall: -1};
      vecs[1] = '{n: 4, din: '{5, 9, 0, 9, 0, 0, 0, 0}, ea: '{0, 5, 9, 9, 0, 0, 0, 0},
                  ed: '{9, 9, 5, 0, 0, 0, 0, 0}, sa: 2, sd: 3, sl: 1, extra: 0, stall: -1};
      vecs[2] = '{n: 8, din: '{7, 6, 5, 4, 3, 2, 1, 0}, ea: '{0, 1, 2, 3, 4, 5, 6, 7},
                  ed: '{7, 6, 5, 4, 3, 2, 1, 0}, sa: 28, sd: 0, sl: 0, extra: 1, stall: -1};
      vecs[3] = '{n: 1, din: '{4, 0, 0, 0, 0, 0, 0, 0}, ea: '{4, 0, 0, 0, 0, 0, 0, 0},
                  ed: '{4, 0, 0, 0, 0, 0, 0, 0}, sa: 0, sd: 0, sl: 0, extra: 0, stall: -1};
      vecs[4] = '{n: 6, din: '{0, 15, 8, 8, 3, 15, 0, 0}, ea: '{0, 3, 8, 8, 15, 15, 0, 0},
                  ed: '{15, 15, 8, 8, 3, 0, 0, 0}, sa: 5, sd: 8, sl: 0, extra: 0, stall: 2};
      rst = 1'b1;
      in_valid = 1'b0;
      start = 1'b0;
      out_ready = 1'b0;
      in_data = 4'd0;
      @(negedge clk);
      chk("rst_in_ready", {7'd0, a_in_ready}, 8'd1);
      chk("rst_busy", {7'd0, a_busy}, 8'd0);
      chk("rst_out_valid", {7'd0, a_out_valid}, 8'd0);
      chk("rst_out_last", {7'd0, a_out_last}, 8'd0);
      chk("rst_out_data", {4'd0, a_out_data}, 8'd0);
      chk("rst_swaps", a_swaps, 8'd0);
      rst = 1'b0;
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      chk("empty_start_busy_a", {7'd0, a_busy}, 8'd0);
      chk("empty_start_busy_d", {7'd0, d_busy}, 8'd0);
      @(negedge clk);
      chk("empty_start_busy2", {7'd0, a_busy}, 8'd0);
      chk("empty_start_ready", {7'd0, a_in_ready}, 8'd1);
      for (int v = 0; v < 5; v++) run_batch(v);
      in_valid = 1'b1;
      in_data = 4'd4;
      @(negedge clk);
      in_valid = 1'b0;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      chk("one_sort_busy", {7'd0, a_busy}, 8'd1);
      chk("one_sort_valid", {7'd0, a_out_valid}, 8'd0);
      @(negedge clk);
      chk("one_unload_valid", {7'd0, a_out_valid}, 8'd1);
      chk("one_unload_data", {4'd0, a_out_data}, 8'd4);
      chk("one_unload_last", {7'd0, a_out_last}, 8'd1);
      chk("one_unload_last_d", {7'd0, d_out_last}, 8'd1);
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      chk("one_done_valid", {7'd0, a_out_valid}, 8'd0);
      chk("one_done_busy", {7'd0, d_busy}, 8'd0);
      for (int k = 0; k < 8; k++) begin
         in_valid = 1'b1;
         in_data = 4'(7 - k);
         @(negedge clk);
      end
      in_valid = 1'b0;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (3) @(negedge clk);
      chk("mid_sort_busy", {7'd0, a_busy}, 8'd1);
      #2 rst = 1'b1;
      @(negedge clk);
      chk("mid_rst_busy", {7'd0, a_busy}, 8'd0);
      chk("mid_rst_valid", {7'd0, a_out_valid}, 8'd0);
      chk("mid_rst_ready", {7'd0, a_in_ready}, 8'd1);
      chk("mid_rst_swaps", a_swaps, 8'd0);
      rst = 1'b0;
      @(negedge clk);
      run_batch(0);
      run_batch(4);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
